// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-input stream multiplexer.
//   mux_mode_t : selection mode (external select or round-robin)
//   mod_inc    : increment an index modulo n
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_t;

    // Next index after idx, wrapping to 0 at n.
    function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter owning the priority pointer.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-channel request
//   advance    : move the pointer to the current winner (on an accepted RR transfer)
//   grant      : one-hot combinational grant
//   grant_idx  : index of the granted channel (0 when nothing is granted)
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int unsigned      cand;

    // Pointer holds the last winner; reset to N-1 so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= IDX_W'(N - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

    // First requester at or after ptr+1, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = mod_inc(32'(ptr), N);
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[IDX_W'(cand)]) begin
                grant[IDX_W'(cand)] = 1'b1;
                grant_idx           = IDX_W'(cand);
                found               = 1'b1;
            end
            cand = mod_inc(cand, N);
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-input, W-bit valid/ready stream multiplexer with a one-entry output register.
//   clk, rst_n : clock, synchronous active-low reset
//   mode       : 0 = external select, 1 = round-robin
//   sel        : channel index used in external-select mode
//   in_valid / in_data / in_ready : per-channel handshake, data packed at [i*W +: W]
//   out_valid / out_data / out_src / out_ready : registered output beat and its source
// in_ready depends combinationally on out_ready so the register can reload while draining.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_IN-1:0]   in_valid,
    input  logic [N_IN*W-1:0] in_data,
    output logic [N_IN-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_src,
    input  logic              out_ready
);

    mux_mode_t         mode_e;
    logic [N_IN-1:0]   sel_grant;
    logic [N_IN-1:0]   rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [N_IN-1:0]   grant;
    logic [SEL_W-1:0]  src_idx;
    logic [W-1:0]      src_data;
    logic              can_load;
    logic              transfer;
    logic              advance;

    assign mode_e = mux_mode_t'(mode);

    rr_arbiter #(
        .N     (N_IN),
        .IDX_W (SEL_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (advance),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // External select; an out-of-range sel matches no channel.
    always_comb begin
        sel_grant = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            sel_grant[i] = (32'(sel) == i) && in_valid[i];
        end
    end

    assign grant   = (mode_e == MODE_RR) ? rr_grant : sel_grant;
    assign src_idx = (mode_e == MODE_RR) ? rr_idx   : sel;

    // Data of the granted channel.
    always_comb begin
        src_data = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                src_data = in_data[i*W +: W];
            end
        end
    end

    assign can_load = ~out_valid | out_ready;
    // Nothing is accepted while reset is asserted.
    assign in_ready = grant & {N_IN{can_load & rst_n}};
    assign transfer = |(in_valid & in_ready);
    assign advance  = transfer & (mode_e == MODE_RR);

    // One-entry output register; data/src hold after the beat drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= src_data;
            out_src   <= src_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;
    localparam int N = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic [1:0]    sel;
    logic [N-1:0]  in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_src;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_valid = 0;
    int m_data  = 0;
    int m_src   = 0;
    int m_ptr   = N - 1;

    stream_mux_n #(.N_IN(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel that should be granted now, or -1.
    function automatic int model_grant();
        if (rst_n !== 1'b1) return -1;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        if (g >= 0 && (m_valid == 0 || out_ready)) return N'(1) << g;
        return '0;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = N - 1;
        end else begin
            g = model_grant();
            if (g >= 0 && (m_valid == 0 || out_ready)) begin
                m_valid = 1;
                m_data  = int'(in_data[g*W +: W]);
                m_src   = g;
                if (mode == 1'b1) m_ptr = g;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model in_ready", 32'(in_ready), 32'(model_ready()));
        chk("model out_valid", 32'(out_valid), 32'(m_valid));
        chk("model out_data", 32'(out_data), 32'(m_data));
        chk("model out_src", 32'(out_src), 32'(m_src));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_seq [6];
        rr_seq = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0;
        in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;

        // Reset held for two edges with everything valid
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", 32'(out_data), 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first rr grant", 32'(in_ready), 32'b0001);

        // Round-robin fairness, one beat per cycle
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("rr src", 32'(out_src), 32'(rr_seq[j]));
            chk("rr valid", 32'(out_valid), 32'h1);
        end

        // Backpressure: ch2 held for three cycles
        step();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall in_ready", 32'(in_ready), 32'h0);
            chk("stall src", 32'(out_src), 32'd2);
            chk("stall data", 32'(out_data), 32'h3);
        end
        #1 out_ready = 1'b1;
        #1 chk("release grant", 32'(in_ready), 32'b1000);
        @(negedge clk);
        chk("reload src", 32'(out_src), 32'd3);
        chk("reload valid", 32'(out_valid), 32'h1);

        // Mode switch keeps the RR pointer
        step();
        @(negedge clk);
        chk("rr0 src", 32'(out_src), 32'd0);
        step();
        mode = 1'b0; sel = 2'd3;
        @(negedge clk);
        chk("rr1 src", 32'(out_src), 32'd1);
        chk("sel3 grant", 32'(in_ready), 32'b1000);
        step();
        step();
        mode = 1'b1;
        @(negedge clk);
        chk("sel beat src", 32'(out_src), 32'd3);
        chk("resume rr grant", 32'(in_ready), 32'b0100);
        step();
        @(negedge clk);
        chk("resume rr src", 32'(out_src), 32'd2);

        // Reset mid-stream while holding a ch1 beat
        #1 in_valid = 4'b0010;
        step();
        out_ready = 1'b0; in_valid = 4'b1111;
        @(negedge clk);
        chk("hold ch1 src", 32'(out_src), 32'd1);
        chk("hold ch1 data", 32'(out_data), 32'h2);
        #1 rst_n = 1'b0;
        #1 chk("rst cycle in_ready", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst grant", 32'(in_ready), 32'b0001);
        step();
        @(negedge clk);
        chk("post rst src", 32'(out_src), 32'd0);
        chk("post rst data", 32'(out_data), 32'h1);

        // External-select passthrough, empty register ignores out_ready
        #1 in_valid = 4'b0000;
        step();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 16'h4A21; out_ready = 1'b0;
        @(negedge clk);
        chk("empty out_valid", 32'(out_valid), 32'h0);
        chk("sel2 grant", 32'(in_ready), 32'b0100);
        step();
        sel = 2'd3; out_ready = 1'b1;
        @(negedge clk);
        chk("sel2 data", 32'(out_data), 32'hA);
        chk("sel2 src", 32'(out_src), 32'd2);
        chk("sel3 no grant", 32'(in_ready), 32'h0);
        step();
        @(negedge clk);
        chk("drain valid", 32'(out_valid), 32'h0);
        chk("drain data held", 32'(out_data), 32'hA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

- Parametrised N-input, W-bit stream multiplexer with a valid/ready handshake on every input and on the output.
- Two selection modes:
  - **External select:** generalised `sel`-driven mux.
  - **Round-robin:** fair arbitration across channels.
- Output is a one-entry pipeline register tagged with the source channel index.
- Sits between several producer channels and a single downstream consumer, replacing hand-built trees of small combinational muxes where backpressure and fairness are needed.

## Interface

Parameters:
- `N_IN`, default 4: number of input channels, ≥ 2.
- `W`, default 4: data width per channel, ≥ 1.
- `SEL_W`, default `$clog2(N_IN)`: derived; do not override.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `mode`  in  1: 0 = external select (MODE_SEL), 1 = round-robin (MODE_RR).
- `sel`  in  SEL_W: channel index used in MODE_SEL; ignored in MODE_RR.
- `in_valid`  in  N_IN: per-channel valid.
- `in_data`  in  N_IN×W: packed; channel i occupies bits [i*W +: W].
- `in_ready`  out  N_IN: per-channel ready; at most one bit set.
- `out_valid`  out  1: output register holds a beat.
- `out_data`  out  W: registered data.
- `out_src`  out  SEL_W: channel index the held beat came from.
- `out_ready`  in  1: consumer accepts the beat.

## Operation

- **Capacity:** `can_load = ~out_valid | out_ready`.
- **Grant:** one-hot `grant[N_IN-1:0]`, computed combinationally each cycle.
- **MODE_SEL:**
  - `grant[sel] = in_valid[sel]`.
  - If `sel ≥ N_IN`, there is no grant.
- **MODE_RR:**
  - Search starts at `ptr+1` modulo N_IN and takes the first channel with `in_valid` set.
  - No valid input means no grant.
- **Ready:** `in_ready[i] = grant[i] & can_load`.
  - Combinational path `out_ready` → `in_ready` is intended and documented.
- **Transfer on channel i:** `in_valid[i] & in_ready[i]`.
  - Next edge: `out_valid ← 1`, `out_data ← in_data[i]`, `out_src ← i`.
- **Consume without refill:** `out_valid & out_ready` with no transfer gives `out_valid ← 0`. `out_data`/`out_src` hold their last values.
- **Simultaneous consume and transfer:** the register reloads with the new beat; `out_valid` stays 1. Full throughput is one beat per cycle.
- **RR pointer `ptr`:**
  - Updates to the granted index only on a transfer.
  - Stalled or no-transfer cycles leave it unchanged.
  - Kept in both modes but updated only in MODE_RR, so switching back to MODE_RR resumes fairness from the last RR winner.
- **Mode/sel changes:** take effect in the same cycle's combinational grant. A beat already in the output register is unaffected.
- **Producer obligation:** keep `in_valid`/`in_data` stable until accepted. The block does not check this.

## Timing

- **Reset values** (`rst_n` low at a rising edge):
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`.
  - `ptr = N_IN-1`, so channel 0 has first RR priority.
  - `in_ready` is all-zero during the reset cycle.
- **Reset mid-operation:** the held beat is discarded and no transfer is accepted in that cycle.
- **Latency:** input transfer at edge k gives `out_valid` = 1 after edge k, visible in cycle k+1.
- **Wrap-around:** after a grant to N_IN-1, the RR search starts at channel 0.
- **Full + stall:** `out_valid = 1` with `out_ready = 0` forces all `in_ready` to 0. Output data and source are held stable.
- **Empty:** `out_valid = 0` means `in_ready` follows `grant` regardless of `out_ready`.

## Structure

- Package `stream_mux_pkg`:
  - `typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t;`
  - Helper function for modulo-N_IN increment.
- Sub-module `rr_arbiter #(N)`:
  - Ports: `clk`, `rst_n`, `req[N]`, `advance`, `grant[N]`, `grant_idx`.
  - Owns `ptr`.
  - `advance` = transfer & MODE_RR.
- Top level contains: mode/select grant mux, `can_load`, output register.

## Test plan

- **Reset:** N_IN=4, W=4; hold `rst_n` low 2 cycles with all inputs valid → `out_valid=0`, `out_data=0`, `in_ready=0000`; the first RR grant after release goes to ch0.
- **MODE_SEL passthrough:** `sel=2`, `in_data[2]=4'hA`, `in_valid=0100`, `out_ready=1` → `in_ready=0100`; next cycle `out_data=A`, `out_src=2`. With `sel=3` and `in_valid[3]=0` → no grant, `in_ready=0000`.
- **RR fairness:** MODE_RR, all four valid continuously, `out_ready=1` → `out_src` sequence 0,1,2,3,0,1 with one beat per cycle.
- **Backpressure:** MODE_RR, `out_ready=0` for 3 cycles after the first load → `in_ready=0000`, `out_data`/`out_src` stable, `ptr` unchanged. Raising `out_ready` gives simultaneous consume and reload, and the next channel is granted.
- **Mode switch pointer retention:** RR grants 0,1, switch to MODE_SEL with `sel=3` for 2 beats, return to MODE_RR with all valid → next RR grant is ch2.
- **Reset mid-stream:** `out_valid=1` holding ch1 data, `rst_n` low one cycle → `out_valid=0`, beat dropped, `ptr=3`; the next RR grant is ch0.
